// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-4 packet-aware stream demux.
package demux_pkg;
   localparam int NUM_OUT = 4;
   localparam int SEL_W   = 2;

   typedef enum logic {IDLE, LOCKED} state_e;

   localparam logic [SEL_W-1:0] SEL_D0 = 2'b00;
   localparam logic [SEL_W-1:0] SEL_D1 = 2'b01;
   localparam logic [SEL_W-1:0] SEL_D2 = 2'b10;
   localparam logic [SEL_W-1:0] SEL_D3 = 2'b11;

   function automatic logic [NUM_OUT-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
      logic [NUM_OUT-1:0] oh;
      oh = '0;
      case (sel)
         SEL_D0:  oh = 4'b0001;
         SEL_D1:  oh = 4'b0010;
         SEL_D2:  oh = 4'b0100;
         SEL_D3:  oh = 4'b1000;
         default: oh = '0;
      endcase
      return oh;
   endfunction
endpackage

// File: rtl/demux_out_reg.sv
// One-entry valid/ready output buffer, 1-cycle latency from load.
// Holds data/last while valid && !ready; reloads on the same cycle it drains.
module demux_out_reg #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [DW-1:0] data_in,
   input  logic          last_in,
   input  logic          ready,
   output logic          valid,
   output logic [DW-1:0] data,
   output logic          last
);
   logic          valid_q, valid_d;
   logic [DW-1:0] data_q;
   logic          last_q;

   // The top only asserts load when the buffer is empty or draining this cycle.
   always_comb begin
      valid_d = load | (valid_q & ~ready);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         if (load) begin
            data_q <= data_in;
            last_q <= last_in;
         end
      end
   end

   assign valid = valid_q;
   assign data  = data_q;
   assign last  = last_q;
endmodule

// File: rtl/demux_1to4_stream.sv
// Packet-aware 1-to-4 stream demux, 1-cycle latency; in_ready follows only the target buffer.
// Select locks on the first beat until in_last. DEMUX_COUNT_EN adds per-output beat_cnt.
module demux_1to4_stream
   import demux_pkg::*;
#(
   parameter int DW = 8
`ifdef DEMUX_COUNT_EN
   ,
   parameter int CNT_W = 16
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DW-1:0]         in_data,
   input  logic [SEL_W-1:0]      in_sel,
   input  logic                  in_last,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [NUM_OUT*DW-1:0] out_data,
   output logic [NUM_OUT-1:0]    out_last,
   output logic [NUM_OUT-1:0]    out_valid,
   input  logic [NUM_OUT-1:0]    out_ready,
   output logic                  busy,
`ifdef DEMUX_COUNT_EN
   output logic [SEL_W-1:0]      cur_sel,
   output logic [NUM_OUT*CNT_W-1:0] beat_cnt
`else
   output logic [SEL_W-1:0]      cur_sel
`endif
);
   state_e             state_q, state_d;
   logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
   logic [SEL_W-1:0]   target;
   logic               accept;
   logic [NUM_OUT-1:0] load;

   always_comb begin
      target    = (state_q == LOCKED) ? cur_sel_q : in_sel;
      in_ready  = !out_valid[target] || out_ready[target];
      accept    = in_valid && in_ready;
      load      = accept ? sel_onehot(target) : '0;
      state_d   = state_q;
      cur_sel_d = cur_sel_q;
      case (state_q)
         IDLE: begin
            if (accept && !in_last) begin
               state_d   = LOCKED;
               cur_sel_d = in_sel;
            end
         end
         LOCKED: begin
            if (accept && in_last) begin
               state_d   = IDLE;
               cur_sel_d = SEL_D0;
            end
         end
         default: begin
            state_d   = IDLE;
            cur_sel_d = SEL_D0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cur_sel_q <= SEL_D0;
      end else begin
         state_q   <= state_d;
         cur_sel_q <= cur_sel_d;
      end
   end

   assign busy    = (state_q == LOCKED);
   assign cur_sel = cur_sel_q;

   for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
      demux_out_reg #(.DW(DW)) u_out (
         .clk     (clk),
         .reset   (reset),
         .load    (load[g]),
         .data_in (in_data),
         .last_in (in_last),
         .ready   (out_ready[g]),
         .valid   (out_valid[g]),
         .data    (out_data[g*DW +: DW]),
         .last    (out_last[g])
      );
   end

`ifdef DEMUX_COUNT_EN
   logic [CNT_W-1:0] cnt_q [NUM_OUT];

   // Counts consumer handshakes, so a beat discarded by reset is never counted.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_OUT; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_OUT; i++)
            if (out_valid[i] && out_ready[i]) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
   end

   for (genvar g = 0; g < NUM_OUT; g++) begin : g_cnt
      assign beat_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
   end
`endif
endmodule

// File: tb/tb_demux_1to4_stream.sv
// Bench for demux_1to4_stream: routing table, packet lock, backpressure, drain, reset, counters.
module tb_demux_1to4_stream;
   localparam int DW    = 8;
   localparam int CNT_W = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [DW-1:0] in_data = '0;
   logic [1:0]    in_sel = '0;
   logic          in_last = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [4*DW-1:0] out_data;
   logic [3:0]    out_last;
   logic [3:0]    out_valid;
   logic [3:0]    out_ready = 4'hF;
   logic          busy;
   logic [1:0]    cur_sel;
`ifdef DEMUX_COUNT_EN
   logic [4*CNT_W-1:0] beat_cnt;
`endif

   always #5 clk = ~clk;

   demux_1to4_stream #(
      .DW(DW)
`ifdef DEMUX_COUNT_EN
      , .CNT_W(CNT_W)
`endif
   ) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
      .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
`ifdef DEMUX_COUNT_EN
      .cur_sel(cur_sel), .beat_cnt(beat_cnt)
`else
      .cur_sel(cur_sel)
`endif
   );

   typedef struct {
      int         port;
      logic [7:0] data;
      logic       last;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [1:0] sel;
      logic [7:0] data;
      logic [3:0] exp_vld;
   } vec_t;
   vec_t vt[4];

   int   checks = 0;
   int   failures = 0;
   bit   m_locked = 1'b0;
   logic [1:0] m_sel = 2'b00;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] slice(input int i);
      return out_data[i*8 +: 8];
   endfunction

   // Drives one beat, waits for acceptance, records where the spec says it must land.
   task automatic send(input logic [1:0] sel, input logic [7:0] d, input logic last);
      bit   done;
      exp_t e;
      done = 1'b0;
      in_valid = 1'b1; in_sel = sel; in_data = d; in_last = last;
      e.port = m_locked ? int'(m_sel) : int'(sel);
      e.data = d;
      e.last = last;
      for (int c = 0; c < 50 && !done; c++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(e);
            if (!m_locked && !last) begin
               m_locked = 1'b1;
               m_sel = sel;
            end else if (m_locked && last) begin
               m_locked = 1'b0;
               m_sel = 2'b00;
            end
            @(posedge clk); #1;
            done = 1'b1;
         end
      end
      in_valid = 1'b0;
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: beat %0h not accepted, required acceptance", d);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      sb.delete();
      m_locked = 1'b0;
      m_sel = 2'b00;
   endtask

   // Scoreboard: every consumer handshake must match the oldest pending beat for that port.
   always @(negedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) begin
            if (out_valid[i] && out_ready[i]) begin
               int idx;
               idx = -1;
               for (int k = 0; k < sb.size(); k++)
                  if (idx < 0 && sb[k].port == i) idx = k;
               if (idx < 0) begin
                  checks++;
                  failures++;
                  $display("FAIL sb_unexpected: port %0d delivered %0h, required nothing", i, slice(i));
               end else begin
                  check("sb_data", slice(i), sb[idx].data);
                  check("sb_last", out_last[i], sb[idx].last);
                  sb.delete(idx);
               end
            end
         end
      end
   end

   initial begin
      vt[0] = '{2'b00, 8'hA5, 4'b0001};
      vt[1] = '{2'b01, 8'h3C, 4'b0010};
      vt[2] = '{2'b10, 8'h0F, 4'b0100};
      vt[3] = '{2'b11, 8'hF0, 4'b1000};

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 4'b0000);
      check("rst_out_data", out_data, 32'h0);
      check("rst_out_last", out_last, 4'b0000);
      check("rst_busy", busy, 1'b0);
      check("rst_cur_sel", cur_sel, 2'b00);
      @(posedge clk); #1;
      reset = 1'b0;

      // Single-beat routing table
      for (int k = 0; k < 4; k++) begin
         send(vt[k].sel, vt[k].data, 1'b1);
         check("tbl_out_valid", out_valid, vt[k].exp_vld);
         check("tbl_slice", slice(int'(vt[k].sel)), vt[k].data);
         check("tbl_busy", busy, 1'b0);
      end
      @(posedge clk); #1;

      // 3-beat packet locked to out2 despite in_sel changing
      send(2'b10, 8'h11, 1'b0);
      check("pkt_busy1", busy, 1'b1);
      check("pkt_sel1", cur_sel, 2'b10);
      check("pkt_vld1", out_valid, 4'b0100);
      send(2'b01, 8'h22, 1'b0);
      check("pkt_busy2", busy, 1'b1);
      check("pkt_sel2", cur_sel, 2'b10);
      check("pkt_vld2", out_valid, 4'b0100);
      send(2'b01, 8'h33, 1'b1);
      check("pkt_busy3", busy, 1'b0);
      check("pkt_sel3", cur_sel, 2'b00);
      check("pkt_vld3", out_valid, 4'b0100);
      check("pkt_data3", slice(2), 8'h33);
      @(posedge clk); #1;

      // Backpressure on out3
      out_ready = 4'b0111;
      send(2'b11, 8'h77, 1'b1);
      check("bp_vld", out_valid[3], 1'b1);
      in_valid = 1'b1; in_sel = 2'b11; in_data = 8'h88; in_last = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("bp_in_ready", in_ready, 1'b0);
         check("bp_hold_data", slice(3), 8'h77);
         check("bp_hold_vld", out_valid[3], 1'b1);
      end
      @(posedge clk); #1;
      out_ready = 4'hF;
      @(negedge clk);
      check("bp_release_ready", in_ready, 1'b1);
      sb.push_back('{3, 8'h88, 1'b1});
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_reload_vld", out_valid[3], 1'b1);
      check("bp_reload_data", slice(3), 8'h88);
      @(posedge clk); #1;

      // Stalled out0 must not block out1
      out_ready = 4'b1110;
      send(2'b00, 8'h5A, 1'b1);
      send(2'b01, 8'h6B, 1'b1);
      check("drn_vld", out_valid, 4'b0011);
      check("drn_d0", slice(0), 8'h5A);
      check("drn_d1", slice(1), 8'h6B);
      @(posedge clk); #1;
      check("drn_vld2", out_valid, 4'b0001);
      check("drn_d0_hold", slice(0), 8'h5A);
      out_ready = 4'hF;
      @(posedge clk); #1;

      // Reset while locked with buffered beats
      out_ready = 4'b1010;
      send(2'b00, 8'hB0, 1'b1);
      send(2'b10, 8'hC1, 1'b0);
      check("rl_busy_pre", busy, 1'b1);
      do_reset();
      out_ready = 4'hF;
      check("rl_out_valid", out_valid, 4'b0000);
      check("rl_busy", busy, 1'b0);
      check("rl_cur_sel", cur_sel, 2'b00);
      send(2'b11, 8'hD3, 1'b1);
      check("rl_route_vld", out_valid, 4'b1000);
      check("rl_route_data", slice(3), 8'hD3);
      @(posedge clk); #1;

`ifdef DEMUX_COUNT_EN
      do_reset();
      for (int k = 0; k < 5; k++) send(2'b01, 8'(8'h40 + k), 1'b1);
      for (int k = 0; k < 2; k++) send(2'b10, 8'(8'h50 + k), 1'b1);
      repeat (2) @(posedge clk);
      #1;
      check("cnt0", beat_cnt[0*CNT_W +: CNT_W], 64'd0);
      check("cnt1", beat_cnt[1*CNT_W +: CNT_W], 64'd5);
      check("cnt2", beat_cnt[2*CNT_W +: CNT_W], 64'd2);
      check("cnt3", beat_cnt[3*CNT_W +: CNT_W], 64'd0);
`endif

      repeat (3) @(posedge clk);
      #1;
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
